// File: rtl/ddr_wr_burst_arb.sv
// Round-robin arbiter sharing one DDR write-burst port among NUM_CH burst engines.
// A grant covers one complete burst; burst count and a sticky stall flag are exported.
module ddr_wr_burst_arb #(
  parameter int          NUM_CH      = 4,
  parameter int          DDR_ADDR_WD = 32,
  parameter int          DDR_DATA_WD = 512,
  parameter logic [31:0] TIMEOUT_CYC = 32'd65536
) (
  input  logic                          ddr_clk,
  input  logic                          ddr_rst,
  input  logic                          cfg_rst,
  input  logic [NUM_CH-1:0]             ch_wr_burst_req,
  input  logic [NUM_CH*10-1:0]          ch_wr_burst_len,
  input  logic [NUM_CH*DDR_ADDR_WD-1:0] ch_wr_burst_addr,
  input  logic [NUM_CH*DDR_DATA_WD-1:0] ch_wr_burst_data,
  output logic [NUM_CH-1:0]             ch_wr_burst_data_req,
  output logic [NUM_CH-1:0]             ch_wr_burst_finish,
  output logic                          wr_burst_req,
  output logic [9:0]                    wr_burst_len,
  output logic [DDR_ADDR_WD-1:0]        wr_burst_addr,
  input  logic                          wr_burst_data_req,
  output logic [DDR_DATA_WD-1:0]        wr_burst_data,
  input  logic                          wr_burst_finish,
  output logic [2:0]                    grant_id,
  output logic                          arb_busy,
  output logic                          stall_err,
  output logic [31:0]                   burst_cnt
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_DONE} state_e;

  state_e                 state_q;
  logic [2:0]             rr_q, gid_q, rr_d;
  logic                   req_q, busy_q, stall_q;
  logic [9:0]             len_q;
  logic [DDR_ADDR_WD-1:0] addr_q;
  logic [31:0]            cnt_q, cnt_d, tmo_q, tmo_d;

  logic [NUM_CH-1:0][9:0]             len_a;
  logic [NUM_CH-1:0][DDR_ADDR_WD-1:0] addr_a;
  logic [NUM_CH-1:0][DDR_DATA_WD-1:0] data_a;
  logic [NUM_CH-1:0]                  elig;

  assign len_a  = ch_wr_burst_len;
  assign addr_a = ch_wr_burst_addr;
  assign data_a = ch_wr_burst_data;

  // A zero-length request would never see a finish, so it is not eligible.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
    assign elig[i] = ch_wr_burst_req[i] & (|len_a[i]);
  end

  // Walk downward so the last hit is the first eligible index at/after rr_q.
  logic       pick_vld;
  logic [2:0] pick_id;
  logic [3:0] cand;
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NUM_CH)) cand = cand - 4'(NUM_CH);
      if (elig[cand[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = cand[2:0];
      end
    end
  end

  logic in_burst;
  assign in_burst = (state_q == S_GRANT) || (state_q == S_BURST);
  assign rr_d     = (gid_q == 3'(NUM_CH - 1)) ? 3'd0 : gid_q + 3'd1;
  assign cnt_d    = cnt_q + 32'd1;
  assign tmo_d    = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;

  always_comb begin
    ch_wr_burst_data_req = '0;
    ch_wr_burst_finish   = '0;
    wr_burst_data        = '0;
    if (in_burst) begin
      ch_wr_burst_data_req[gid_q[CH_W-1:0]] = wr_burst_data_req;
      ch_wr_burst_finish[gid_q[CH_W-1:0]]   = wr_burst_finish;
      wr_burst_data                         = data_a[gid_q[CH_W-1:0]];
    end
  end

  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      req_q   <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      if (in_burst) begin
        tmo_q <= tmo_d;
        if (tmo_q >= TIMEOUT_CYC - 32'd1) stall_q <= 1'b1;
      end
      // cfg_rst wins over a coincident finish increment and stall set.
      if (cfg_rst) begin
        cnt_q   <= '0;
        stall_q <= 1'b0;
      end else if (state_q == S_BURST && wr_burst_finish) begin
        cnt_q <= cnt_d;
      end
      case (state_q)
        S_IDLE: if (pick_vld) begin
          gid_q   <= pick_id;
          len_q   <= len_a[pick_id[CH_W-1:0]];
          addr_q  <= addr_a[pick_id[CH_W-1:0]];
          tmo_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_GRANT;
        end
        S_GRANT: begin
          req_q   <= 1'b1;
          state_q <= S_BURST;
        end
        S_BURST: if (wr_burst_finish) begin
          req_q   <= 1'b0;
          rr_q    <= rr_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_burst_req  = req_q;
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = addr_q;
  assign grant_id      = gid_q;
  assign arb_busy      = busy_q;
  assign stall_err     = stall_q;
  assign burst_cnt     = cnt_q;

endmodule

// File: tb/tb_ddr_wr_burst_arb.sv
// Scoreboard bench for ddr_wr_burst_arb: expected grants are queued by the stimulus
// and checked by a monitor; a DDR model pumps data_req beats and finish pulses.
module tb_ddr_wr_burst_arb;
  localparam int NCH = 4, AW = 32, DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ddr_rst, cfg_rst, cfg_s, cfg_m;
  logic [NCH-1:0]    ch_req, ch_dreq, ch_fin;
  logic [NCH*10-1:0] ch_len;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic              wr_burst_req, ddr_dreq, ddr_fin, arb_busy, stall_err;
  logic [9:0]        wr_burst_len;
  logic [AW-1:0]     wr_burst_addr;
  logic [DW-1:0]     wr_burst_data;
  logic [2:0]        grant_id;
  logic [31:0]       burst_cnt;
  logic              hold_fin = 1'b0, fin_cfg = 1'b0;

  assign cfg_rst = cfg_s | cfg_m;

  ddr_wr_burst_arb #(.NUM_CH(NCH), .DDR_ADDR_WD(AW), .DDR_DATA_WD(DW), .TIMEOUT_CYC(32'd100)) dut (
    .ddr_clk(clk), .ddr_rst(ddr_rst), .cfg_rst(cfg_rst),
    .ch_wr_burst_req(ch_req), .ch_wr_burst_len(ch_len), .ch_wr_burst_addr(ch_addr),
    .ch_wr_burst_data(ch_data), .ch_wr_burst_data_req(ch_dreq), .ch_wr_burst_finish(ch_fin),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(ddr_dreq), .wr_burst_data(wr_burst_data), .wr_burst_finish(ddr_fin),
    .grant_id(grant_id), .arb_busy(arb_busy), .stall_err(stall_err), .burst_cnt(burst_cnt));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] pat(int c);
    return {32'hDA7A_0000 + 32'(c), 32'h5A5A_0000 + 32'(c)};
  endfunction

  // mode 0: no timing check, 1: rise at cycle 'rise', 2: rise 4 cycles after last finish cycle
  typedef struct {
    logic [2:0]  gid;
    logic [9:0]  len;
    logic [31:0] addr;
    int          mode;
    int          rise;
  } exp_t;
  exp_t exp_q[$];

  task automatic set_ch(int c, int len, logic [31:0] a);
    ch_len[c*10 +: 10] = 10'(len);
    ch_addr[c*AW +: AW] = a;
  endtask

  task automatic push(int c, int mode);
    exp_t e;
    e.gid  = 3'(c);
    e.len  = ch_len[c*10 +: 10];
    e.addr = ch_addr[c*AW +: AW];
    e.mode = mode;
    e.rise = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_fin(int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ch_fin[c] && n < 400);
    chk($sformatf("fin_seen_ch%0d", c), 64'(ch_fin[c]), 64'd1);
  endtask

  task automatic wait_req();
    int n = 0;
    do begin @(negedge clk); n++; end while (!wr_burst_req && n < 100);
    chk("wr_burst_req_seen", 64'(wr_burst_req), 64'd1);
  endtask

  // DDR controller model: len data_req beats, then a finish pulse (optionally held back).
  initial begin : ddr_model
    int  n;
    logic ab;
    ddr_dreq = 1'b0; ddr_fin = 1'b0; cfg_m = 1'b0;
    forever begin
      tick();
      if (wr_burst_req) begin
        n  = int'(wr_burst_len);
        ab = 1'b0;
        for (int b = 0; b < n && !ab; b++) begin
          ddr_dreq = 1'b1;
          tick();
          if (!wr_burst_req) ab = 1'b1;
        end
        ddr_dreq = 1'b0;
        while (hold_fin && !ab) begin
          tick();
          if (!wr_burst_req) ab = 1'b1;
        end
        if (!ab) begin
          ddr_fin = 1'b1; cfg_m = fin_cfg;
          tick();
          ddr_fin = 1'b0; cfg_m = 1'b0;
        end
      end
    end
  end

  logic       prev_req = 1'b0;
  logic [2:0] cur      = '0;
  int         last_fin = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_burst_req && !prev_req) begin
        chk("grant_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          cur = e.gid;
          chk("grant_id", 64'(grant_id), 64'(e.gid));
          chk("wr_burst_len", 64'(wr_burst_len), 64'(e.len));
          chk("wr_burst_addr", 64'(wr_burst_addr), 64'(e.addr));
          if (e.mode == 1) chk("req_rise_cyc", 64'(cyc), 64'(e.rise));
          if (e.mode == 2) chk("gap_after_finish", 64'(cyc - last_fin), 64'd4);
        end
      end
      if (wr_burst_req && ddr_dreq) begin
        chk("ch_data_req", 64'(ch_dreq), 64'd1 << cur);
        chk("wr_burst_data", 64'(wr_burst_data), 64'(pat(int'(cur))));
      end
      if (wr_burst_req && ddr_fin) begin
        chk("ch_finish", 64'(ch_fin), 64'd1 << cur);
        last_fin = cyc;
      end
      prev_req = wr_burst_req;
    end
  end

  initial begin : stim
    int c0, n;
    ddr_rst = 1'b1; cfg_s = 1'b0; ch_req = '0; ch_len = '0; ch_addr = '0;
    for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = pat(c);
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(wr_burst_req), 64'd0);
    chk("rst_len", 64'(wr_burst_len), 64'd0);
    chk("rst_addr", 64'(wr_burst_addr), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_stall", 64'(stall_err), 64'd0);
    chk("rst_cnt", 64'(burst_cnt), 64'd0);
    chk("rst_data", 64'(wr_burst_data), 64'd0);
    tick(); ddr_rst = 1'b0;
    repeat (2) tick();

    // single request on ch1
    set_ch(1, 16, 32'h1000);
    tick(); push(1, 1); ch_req[1] = 1'b1;
    wait_fin(1); tick(); ch_req[1] = 1'b0;
    @(negedge clk); chk("cnt_after_single", 64'(burst_cnt), 64'd1);

    // len=0 on ch2 is never granted; ch3 is
    set_ch(2, 0, 32'h2000); set_ch(3, 8, 32'h3000);
    tick(); push(3, 1); ch_req[2] = 1'b1; ch_req[3] = 1'b1;
    wait_fin(3); tick(); ch_req[3] = 1'b0;
    repeat (20) @(negedge clk);
    chk("len0_not_busy", 64'(arb_busy), 64'd0);
    tick(); ch_req[2] = 1'b0;

    // all four continuously: 0,1,2,3,0 with 3 idle cycles between bursts
    for (int c = 0; c < NCH; c++) set_ch(c, 4, 32'h4000 + 32'(c) * 32'h100);
    tick(); push(0, 1); push(1, 2); push(2, 2); push(3, 2); push(0, 2);
    ch_req = '1;
    n = 0;
    while (burst_cnt != 32'd7 && n < 500) begin @(negedge clk); n++; end
    chk("cnt_after_rr", 64'(burst_cnt), 64'd7);
    tick(); ch_req = '0;
    repeat (3) tick();

    // timeout: finish withheld, stall_err rises 100 cycles after grant entry
    set_ch(1, 2, 32'h1100);
    tick(); push(1, 1); ch_req[1] = 1'b1; hold_fin = 1'b1; c0 = cyc;
    while (cyc < c0 + 100) @(negedge clk);
    chk("stall_before_tmo", 64'(stall_err), 64'd0);
    @(negedge clk);
    chk("stall_at_tmo", 64'(stall_err), 64'd1);
    tick(); hold_fin = 1'b0;
    wait_fin(1); tick(); ch_req[1] = 1'b0;
    @(negedge clk);
    chk("stall_sticky", 64'(stall_err), 64'd1);
    chk("cnt_after_tmo", 64'(burst_cnt), 64'd8);

    // cfg_rst during a burst clears counters but not the burst
    set_ch(2, 2, 32'h2200);
    tick(); push(2, 0); ch_req[2] = 1'b1; hold_fin = 1'b1;
    wait_req();
    tick(); cfg_s = 1'b1;
    tick(); cfg_s = 1'b0;
    @(negedge clk);
    chk("cfg_cnt", 64'(burst_cnt), 64'd0);
    chk("cfg_stall", 64'(stall_err), 64'd0);
    chk("cfg_burst_alive", 64'(wr_burst_req), 64'd1);
    tick(); hold_fin = 1'b0;
    wait_fin(2); tick(); ch_req[2] = 1'b0;
    @(negedge clk); chk("cnt_after_cfg", 64'(burst_cnt), 64'd1);

    // cfg_rst coincident with finish drops the increment
    set_ch(3, 3, 32'h3300);
    fin_cfg = 1'b1;
    tick(); push(3, 0); ch_req[3] = 1'b1;
    wait_fin(3); tick(); ch_req[3] = 1'b0; fin_cfg = 1'b0;
    @(negedge clk); chk("cnt_cfg_and_fin", 64'(burst_cnt), 64'd0);

    // move rr to 2, then ddr_rst mid-burst on ch2
    set_ch(1, 2, 32'h1500);
    tick(); push(1, 0); ch_req[1] = 1'b1;
    wait_fin(1); tick(); ch_req[1] = 1'b0;
    set_ch(2, 6, 32'h2600);
    tick(); push(2, 0); ch_req[2] = 1'b1; hold_fin = 1'b1;
    wait_req();
    repeat (3) @(negedge clk);
    ddr_rst = 1'b1; #1;
    chk("mid_rst_req", 64'(wr_burst_req), 64'd0);
    chk("mid_rst_len", 64'(wr_burst_len), 64'd0);
    chk("mid_rst_addr", 64'(wr_burst_addr), 64'd0);
    chk("mid_rst_gid", 64'(grant_id), 64'd0);
    chk("mid_rst_busy", 64'(arb_busy), 64'd0);
    chk("mid_rst_cnt", 64'(burst_cnt), 64'd0);
    chk("mid_rst_chfin", 64'(ch_fin), 64'd0);
    tick(); ch_req[2] = 1'b0; hold_fin = 1'b0;
    tick(); ddr_rst = 1'b0;

    // rr restarts at 0: ch1 before ch3
    set_ch(3, 2, 32'h3700);
    tick(); push(1, 1); push(3, 2); ch_req[1] = 1'b1; ch_req[3] = 1'b1;
    wait_fin(1); tick(); ch_req[1] = 1'b0;
    wait_fin(3); tick(); ch_req[3] = 1'b0;
    @(negedge clk); chk("cnt_after_rst", 64'(burst_cnt), 64'd2);

    repeat (5) tick();
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
